// File: rtl/four_bank_mem.sv
// Four-bank interleaved word memory for the cache memory port.
// Banks are selected by Addr[2:1]; reads return two cycles after acceptance.
module four_bank_mem #(
  parameter int MEM_AW    = 15,
  parameter int BANK_BUSY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        data_valid,
  output logic        Stall,
  output logic [3:0]  Busy,
  output logic        err
);

  localparam logic [1:0] CNT_LOAD = 2'(BANK_BUSY - 1);

  logic [1:0]        bank;
  logic              req;
  logic              acc;
  logic [MEM_AW-1:0] word_addr;

  logic [3:0][1:0]   cnt_q;
  logic [3:0][1:0]   cnt_d;

  logic [15:0]       mem [2**MEM_AW];
  logic [15:0]       ram_q;
  logic              v1_q, v1_d;
  logic [15:0]       dout_q, dout_d;
  logic              dv_q, dv_d;

  assign word_addr = Addr[MEM_AW:1];

  always_comb begin
    bank  = Addr[2:1];
    req   = Rd | Wr;
    err   = (Rd & Wr) | (req & Addr[0]);
    Stall = req & ~err & Busy[bank];
    acc   = req & ~err & ~Busy[bank];
  end

  // A fresh acceptance reloads the counter even if it is just reaching zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      assign cnt_d[gi] = (acc && (bank == 2'(gi))) ? CNT_LOAD :
                         ((cnt_q[gi] != 2'd0) ? cnt_q[gi] - 2'd1 : 2'd0);
      assign Busy[gi]  = (cnt_q[gi] != 2'd0);
    end
  endgenerate

  always_comb begin
    v1_d   = acc & Rd;
    dv_d   = v1_q;
    dout_d = v1_q ? ram_q : 16'h0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      v1_q   <= 1'b0;
      dv_q   <= 1'b0;
      dout_q <= 16'h0000;
    end else begin
      cnt_q  <= cnt_d;
      v1_q   <= v1_d;
      dv_q   <= dv_d;
      dout_q <= dout_d;
    end
  end

  // Storage and its read register carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (acc && Wr && !rst) begin
      mem[word_addr] <= DataIn;
    end
    if (acc && Rd) begin
      ram_q <= mem[word_addr];
    end
  end

  assign DataOut    = dout_q;
  assign data_valid = dv_q;

endmodule

// File: tb/tb_four_bank_mem.sv
// Directed bench for four_bank_mem: one drive per cycle, outputs sampled on the falling edge.
module tb_four_bank_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        data_valid;
  logic        Stall;
  logic [3:0]  Busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  four_bank_mem #(.MEM_AW(15), .BANK_BUSY(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .Addr       (Addr),
    .DataIn     (DataIn),
    .Rd         (Rd),
    .Wr         (Wr),
    .DataOut    (DataOut),
    .data_valid (data_valid),
    .Stall      (Stall),
    .Busy       (Busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a new cycle: apply inputs just after the rising edge, return at the falling edge.
  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    Rd     = rd;
    Wr     = wr;
    Addr   = a;
    DataIn = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] exp);
    chk({tag, "_dv"}, {15'd0, data_valid}, 16'd1);
    chk({tag, "_data"}, DataOut, exp);
  endtask

  task automatic chk_nodv(input string tag);
    chk({tag, "_nodv"}, {15'd0, data_valid}, 16'd0);
    chk({tag, "_dout0"}, DataOut, 16'h0000);
  endtask

  logic [15:0] fill_val [4];
  logic [15:0] old_val  [4];
  logic [15:0] wb_val   [4];

  initial begin
    fill_val = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    old_val  = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};
    wb_val   = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};

    // Reset state, with a read request presented during reset
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
    @(negedge clk);
    chk("rst_busy", {12'd0, Busy}, 16'h0000);
    chk_nodv("rst");
    chk("rst_stall_idle", {15'd0, Stall}, 16'd0);
    chk("rst_err_idle", {15'd0, err}, 16'd0);
    Rd = 1'b1; Addr = 16'h0040;
    #1;
    chk("rst_stall_req", {15'd0, Stall}, 16'd0);
    Rd = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Write then read the same word
    drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("wr_stall", {15'd0, Stall}, 16'd0);
    chk("wr_err", {15'd0, err}, 16'd0);
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      chk($sformatf("wr_busy_t%0d", i), {12'd0, Busy}, 16'h0001);
    end
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("rd_busy_free", {12'd0, Busy}, 16'h0000);
    chk("rd_stall", {15'd0, Stall}, 16'd0);
    idle(1);
    chk_nodv("rd_t5");
    idle(1);
    chk_rd("rd_t6", 16'hBEEF);
    idle(1);
    chk_nodv("rd_t7");

    // Preload: 0x0048 for the conflict test, then the line 0x0040..0x0046
    drive(1'b0, 1'b1, 16'h0048, 16'h5555);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 16'h0040 + 16'(2 * i), fill_val[i]);
      chk($sformatf("pre_stall_%0d", i), {15'd0, Stall}, 16'd0);
    end

    // Line fill: four reads back to back
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h0040 + 16'(2 * i), 16'h0000);
      chk($sformatf("fill_stall_%0d", i), {15'd0, Stall}, 16'd0);
      if (i < 2) chk_nodv($sformatf("fill_t%0d", i));
      else       chk_rd($sformatf("fill_w%0d", i - 2), fill_val[i - 2]);
    end
    idle(1);
    chk_rd("fill_w2", fill_val[2]);
    idle(1);
    chk_rd("fill_w3", fill_val[3]);
    idle(1);
    chk_nodv("fill_end");

    // Bank conflict on bank 0
    drive(1'b1, 1'b0, 16'h0040, 16'h0000);
    chk("conf_first_stall", {15'd0, Stall}, 16'd0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 16'h0048, 16'h0000);
      chk($sformatf("conf_stall_t%0d", i), {15'd0, Stall}, 16'd1);
      chk($sformatf("conf_busy_t%0d", i), {12'd0, Busy}, 16'h0001);
      if (i == 2) chk_rd("conf_first", 16'h1111);
    end
    drive(1'b1, 1'b0, 16'h0048, 16'h0000);
    chk("conf_accept", {15'd0, Stall}, 16'd0);
    idle(1);
    chk_nodv("conf_t5");
    idle(1);
    chk_rd("conf_t6", 16'h5555);
    idle(1);

    // Illegal requests against a known word
    drive(1'b0, 1'b1, 16'h0020, 16'h7777);
    idle(3);
    drive(1'b1, 1'b1, 16'h0020, 16'hDEAD);
    chk("ill_rw_err", {15'd0, err}, 16'd1);
    chk("ill_rw_stall", {15'd0, Stall}, 16'd0);
    drive(1'b1, 1'b0, 16'h0011, 16'h0000);
    chk("ill_odd_err", {15'd0, err}, 16'd1);
    chk("ill_odd_stall", {15'd0, Stall}, 16'd0);
    chk("ill_odd_busy", {12'd0, Busy}, 16'h0000);
    idle(1);
    chk("ill_busy_after", {12'd0, Busy}, 16'h0000);
    chk("ill_err_clear", {15'd0, err}, 16'd0);
    chk_nodv("ill_t2");
    idle(1);
    chk_nodv("ill_t3");
    drive(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(1);
    idle(1);
    chk_rd("ill_store", 16'h7777);
    idle(2);

    // Reset in the middle of a read
    drive(1'b1, 1'b0, 16'h0040, 16'h0000);
    @(posedge clk);
    #1;
    Rd = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {12'd0, Busy}, 16'h0000);
    chk_nodv("mid_rst_t1");
    #2 rst = 1'b0;
    idle(1);
    chk_nodv("mid_rst_t2");
    drive(1'b1, 1'b0, 16'h0042, 16'h0000);
    chk("mid_rst_stall", {15'd0, Stall}, 16'd0);
    idle(1);
    chk_nodv("mid_rst_t4");
    idle(1);
    chk_rd("mid_rst_t5", 16'h2222);
    idle(3);

    // Write-back then fill
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 16'h0200 + 16'(2 * i), old_val[i]);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 16'h0100 + 16'(2 * i), wb_val[i]);
      chk($sformatf("wb_stall_%0d", i), {15'd0, Stall}, 16'd0);
    end
    idle(2);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        drive(1'b1, 1'b0, 16'h0200 + 16'(2 * i), 16'h0000);
        chk($sformatf("wbf_stall_%0d", i), {15'd0, Stall}, 16'd0);
      end else begin
        idle(1);
      end
      if (i >= 2) chk_rd($sformatf("wbf_old_%0d", i - 2), old_val[i - 2]);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        drive(1'b1, 1'b0, 16'h0100 + 16'(2 * i), 16'h0000);
        chk($sformatf("wbr_stall_%0d", i), {15'd0, Stall}, 16'd0);
      end else begin
        idle(1);
      end
      if (i >= 2) chk_rd($sformatf("wbr_new_%0d", i - 2), wb_val[i - 2]);
    end
    idle(1);
    chk_nodv("wb_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
